// File: rtl/mtl_pkg.sv
// Shared timing constants and types for the 800x480 MTL panel video output stage.
package mtl_pkg;
  localparam logic [10:0] H_TOTAL = 11'd1056;
  localparam logic [10:0] H_SYNC  = 11'd30;
  localparam logic [10:0] H_ACT0  = 11'd50;
  localparam logic [10:0] H_ACT1  = 11'd849;
  localparam logic [10:0] H_NES0  = 11'd66;
  localparam logic [10:0] H_NES1  = 11'd833;
  localparam logic [9:0]  V_TOTAL = 10'd525;
  localparam logic [9:0]  V_SYNC  = 10'd3;
  localparam logic [9:0]  V_ACT0  = 10'd23;
  localparam logic [9:0]  V_ACT1  = 10'd502;
  localparam logic [9:0]  V_REQ0  = 10'd21;
  localparam logic [9:0]  V_REQ1  = 10'd499;
  localparam int          STAGES  = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Per-pixel control carried alongside the pixel data down the pipeline.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       nes;
    logic       dim;
    logic       req;
    logic [7:0] req_line;
  } ctl_t;

  localparam ctl_t CTL_BLANK = '{hs: 1'b1, vs: 1'b1, default: '0};
endpackage

// File: rtl/mtl_video_out_nes_palette_rgb.sv
// Registered 64-entry 2C02 palette ROM: 6-bit index in, 24-bit RGB out one clock later.
module nes_palette_rgb
  import mtl_pkg::*;
(
  input  logic       clk,
  input  logic [5:0] idx,
  output rgb24_t     rgb
);
  localparam logic [23:0] PAL [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  always_ff @(posedge clk) rgb <= rgb24_t'(PAL[idx]);
endmodule

// File: rtl/mtl_video_out.sv
// NES-to-MTL panel video output: ping-pong line buffer, 3x/2x scaling, palette, sync.
// Optional MTL_SCANLINE_EN halves each channel on the second panel line of every NES line.
module mtl_video_out
  import mtl_pkg::*;
(
  input  logic       i_lcd_clk,
  input  logic       i_lcd_rst,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_x,
  input  logic [5:0] i_wr_idx,
  output logic       o_line_req,
  output logic [7:0] o_req_line,
  output logic       o_hsd,
  output logic       o_vsd,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);
  logic [10:0] xcnt;
  logic [9:0]  ycnt;
  logic [1:0]  sub;
  logic [7:0]  nes_x;
  ctl_t        ctl_c, ctl_s1, ctl_s2;
  logic [STAGES-2:0] vld_pipe;
  logic [5:0]  lbuf [512];
  logic [5:0]  rd_idx;
  logic        rd_bank;
  rgb24_t      pal_rgb, pix;

  // Stage 0: raster counters plus the mod-3 column sub-counter.
  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      xcnt  <= '0;
      ycnt  <= '0;
      sub   <= '0;
      nes_x <= '0;
    end else begin
      xcnt <= (xcnt == H_TOTAL - 11'd1) ? '0 : xcnt + 11'd1;
      if (xcnt == H_TOTAL - 11'd1)
        ycnt <= (ycnt == V_TOTAL - 10'd1) ? '0 : ycnt + 10'd1;
      if (xcnt == H_NES0 - 11'd1) begin
        sub   <= '0;
        nes_x <= '0;
      end else if (sub == 2'd2) begin
        sub   <= '0;
        nes_x <= nes_x + 8'd1;
      end else begin
        sub <= sub + 2'd1;
      end
    end
  end

  always_comb begin
    ctl_c          = CTL_BLANK;
    ctl_c.hs       = (xcnt >= H_SYNC);
    ctl_c.vs       = (ycnt >= V_SYNC);
    ctl_c.act      = (xcnt >= H_ACT0) && (xcnt <= H_ACT1) && (ycnt >= V_ACT0) && (ycnt <= V_ACT1);
    ctl_c.nes      = (xcnt >= H_NES0) && (xcnt <= H_NES1);
    ctl_c.req      = (xcnt == '0) && ycnt[0] && (ycnt >= V_REQ0) && (ycnt <= V_REQ1);
    ctl_c.req_line = 8'((ycnt - V_REQ0) >> 1);
`ifdef MTL_SCANLINE_EN
    ctl_c.dim      = ~ycnt[0];
`endif
  end

  // (ycnt-23) mod 4 == (ycnt+1) mod 4, so the NES line parity is ycnt[1]^ycnt[0].
  assign rd_bank = ycnt[1] ^ ycnt[0];

  // Stage 1: line buffer; writer fills the bank of the requested line.
  always_ff @(posedge i_lcd_clk) begin
    if (i_wr_en) lbuf[{o_req_line[0], i_wr_x}] <= i_wr_idx;
    rd_idx <= lbuf[{rd_bank, nes_x}];
  end

  // Stage 2: palette lookup.
  nes_palette_rgb u_pal (
    .clk (i_lcd_clk),
    .idx (rd_idx),
    .rgb (pal_rgb)
  );

  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      ctl_s1   <= CTL_BLANK;
      ctl_s2   <= CTL_BLANK;
      vld_pipe <= '0;
    end else begin
      ctl_s1   <= ctl_c;
      ctl_s2   <= ctl_s1;
      vld_pipe <= {vld_pipe[STAGES-3:0], 1'b1};
    end
  end

  always_comb begin
    pix = '0;
    if (vld_pipe[STAGES-2] && ctl_s2.act && ctl_s2.nes) pix = pal_rgb;
    if (ctl_s2.dim) begin
      pix.r = {1'b0, pix.r[7:1]};
      pix.g = {1'b0, pix.g[7:1]};
      pix.b = {1'b0, pix.b[7:1]};
    end
  end

  // Stage 3: output register.
  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      o_hsd      <= 1'b1;
      o_vsd      <= 1'b1;
      o_r        <= '0;
      o_g        <= '0;
      o_b        <= '0;
      o_line_req <= 1'b0;
      o_req_line <= '0;
    end else begin
      o_hsd      <= ~vld_pipe[STAGES-2] | ctl_s2.hs;
      o_vsd      <= ~vld_pipe[STAGES-2] | ctl_s2.vs;
      o_r        <= pix.r;
      o_g        <= pix.g;
      o_b        <= pix.b;
      o_line_req <= vld_pipe[STAGES-2] & ctl_s2.req;
      if (vld_pipe[STAGES-2] && ctl_s2.req) o_req_line <= ctl_s2.req_line;
    end
  end
endmodule

// File: tb/tb_mtl_video_out.sv
// Directed bench for mtl_video_out; expectations follow MTL_SCANLINE_EN when defined.
module tb_mtl_video_out;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_x = '0;
  logic [5:0] wr_idx = '0;
  logic       line_req, hsd, vsd;
  logic [7:0] req_line, r, g, b;

  int ncyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int req_total = 0;
  int req_before = 0;
  logic [7:0] last_line = '0;

  always #5 clk = ~clk;

  mtl_video_out dut (
    .i_lcd_clk  (clk),
    .i_lcd_rst  (rst),
    .i_wr_en    (wr_en),
    .i_wr_x     (wr_x),
    .i_wr_idx   (wr_idx),
    .o_line_req (line_req),
    .o_req_line (req_line),
    .o_hsd      (hsd),
    .o_vsd      (vsd),
    .o_r        (r),
    .o_g        (g),
    .o_b        (b)
  );

  // Clocks since reset release; output for counter state k appears at ncyc = k+3.
  always @(posedge clk) ncyc <= rst ? 0 : ncyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [23:0] dim(input logic [23:0] c, input bit odd);
`ifdef MTL_SCANLINE_EN
    if (odd) return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
`endif
    return c;
  endfunction

  task automatic wait_n(input int n);
    int guard = 0;
    while (ncyc < n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (ncyc != n) chk("wait", ncyc, n);
  endtask

  task automatic at(input int x, input int y);
    wait_n(y * 1056 + x + 3);
  endtask

  task automatic chk_rgb(input string tag, input int x, input int y, input logic [23:0] exp);
    at(x, y);
    chk(tag, {r, g, b}, exp);
  endtask

  // Upstream model: answer each request with 256 writes.
  initial begin
    int k;
    logic [7:0] ln;
    forever begin
      @(negedge clk);
      if (line_req) begin
        k  = ncyc - 3;
        ln = req_line;
        chk("req_x", k % 1056, 0);
        chk("req_y_odd", (k / 1056) % 2, 1);
        chk("req_line", ln, (k / 1056 - 21) / 2);
        req_total++;
        last_line = ln;
        for (int i = 0; i < 256; i++) begin
          wr_en  = 1'b1;
          wr_x   = 8'(i);
          wr_idx = (ln == 8'd0) ? 6'(i) : (ln == 8'd5) ? 6'h16 : 6'h30;
          @(negedge clk);
        end
        wr_en = 1'b0;
      end
    end
  end

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_hsd", hsd, 1);
    chk("rst_vsd", vsd, 1);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_req", line_req, 0);
    chk("rst_req_line", req_line, 0);
    rst = 1'b0;

    wait_n(2);
    chk("fill_hsd", hsd, 1);
    chk("fill_vsd", vsd, 1);
    wait_n(3);
    chk("k0_hsd", hsd, 0);
    chk("k0_vsd", vsd, 0);
    at(29, 0);   chk("hsd_29", hsd, 0);
    at(30, 0);   chk("hsd_30", hsd, 1);
    at(1055, 2); chk("vsd_y2", vsd, 0);
    at(0, 3);    chk("vsd_y3", vsd, 1); chk("hsd_x0", hsd, 0);

    // Line 0 replicated: index = x & 0x3F.
    chk_rgb("l23_x49", 49, 23, 24'h000000);
    chk_rgb("l23_x50", 50, 23, 24'h000000);
    chk_rgb("l23_x65", 65, 23, 24'h000000);
    chk_rgb("l23_x66", 66, 23, 24'h7C7C7C);
    chk_rgb("l23_x68", 68, 23, 24'h7C7C7C);
    chk_rgb("l23_x69", 69, 23, 24'h0000FC);
    chk_rgb("l23_x71", 71, 23, 24'h0000FC);
    chk_rgb("l23_x72", 72, 23, 24'h0000BC);
    chk_rgb("l23_x210", 210, 23, 24'hFCFCFC);
    chk_rgb("l23_x827", 827, 23, 24'hF8D8F8);
    chk_rgb("l24_x69", 69, 24, dim(24'h0000FC, 1'b1));
    chk_rgb("l24_x210", 210, 24, dim(24'hFCFCFC, 1'b1));

    // Line 5 solid 0x16.
    chk_rgb("l33_x65", 65, 33, 24'h000000);
    chk_rgb("l33_x66", 66, 33, 24'hF83800);
    chk_rgb("l33_x400", 400, 33, 24'hF83800);
    chk_rgb("l33_x833", 833, 33, 24'hF83800);
    chk_rgb("l33_x834", 834, 33, 24'h000000);
    chk_rgb("l33_x849", 849, 33, 24'h000000);
    chk_rgb("l34_x500", 500, 34, dim(24'hF83800, 1'b1));
    chk("req_count_l34", req_total, 7);

    // Mid-frame reset.
    at(500, 40);
    chk("pre_rst_rgb", {r, g, b}, dim(24'hFCFCFC, 1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_hsd", hsd, 1);
    chk("mid_rst_vsd", vsd, 1);
    chk("mid_rst_rgb", {r, g, b}, 0);
    chk("mid_rst_req_line", req_line, 0);
    req_before = req_total;
    rst = 1'b0;
    wait_n(2);
    chk("refill_hsd", hsd, 1);
    wait_n(3);
    chk("rek0_hsd", hsd, 0);
    chk("rek0_vsd", vsd, 0);
    at(10, 21);
    chk("re_req_count", req_total - req_before, 1);
    chk("re_req_line", last_line, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
